// File: rtl/muxn_scan.sv
// N-channel registered multiplexer with valid/ready output, manual select or auto-scan.
// Optional channel mask enabled by defining MUXN_SCAN_MASK_EN (adds ch_mask input).
module muxn_scan #(
    parameter int N       = 8,
    parameter int W       = 8,
    parameter int DWELL_W = 4,
    localparam int SW     = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*W-1:0]     in_data,
    input  logic               en,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    input  logic [DWELL_W-1:0] dwell,
`ifdef MUXN_SCAN_MASK_EN
    input  logic [N-1:0]       ch_mask,
`endif
    output logic [W-1:0]       out_data,
    output logic [SW-1:0]      out_ch,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [N-1:0]       mask_eff;
    logic [SW-1:0]      ptr;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               mode_q;

    logic               mode_chg;
    logic               scan_dead;
    logic               stall;
    logic               load;
    logic [SW-1:0]      cur_ch;
    logic [DWELL_W-1:0] base_cnt;
    logic [SW-1:0]      nxt_ptr;
    logic [DWELL_W-1:0] nxt_cnt;
    logic [W-1:0]       smp_data;
    logic [SW-1:0]      smp_ch;
    logic               smp_err;
    int                 sel_idx;

`ifdef MUXN_SCAN_MASK_EN
    assign mask_eff = ch_mask;
`else
    assign mask_eff = '1;
`endif

    // First enabled channel at or after 'start', wrapping; lowest offset wins.
    function automatic logic [SW-1:0] first_enabled(input int start, input logic [N-1:0] m);
        int idx;
        first_enabled = SW'(start);
        for (int k = N - 1; k >= 0; k--) begin
            idx = start + k;
            if (idx >= N) idx = idx - N;
            if (m[idx]) first_enabled = SW'(idx);
        end
    endfunction

    function automatic logic [SW-1:0] next_after(input logic [SW-1:0] c, input logic [N-1:0] m);
        int start;
        start = (int'(c) == N - 1) ? 0 : int'(c) + 1;
        next_after = first_enabled(start, m);
    endfunction

    assign mode_chg  = mode != mode_q;
    assign scan_dead = mode & ~(|mask_eff);
    assign stall     = out_valid & ~out_ready;
    assign load      = en & (~out_valid | out_ready) & ~scan_dead;

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        base_cnt = mode_chg ? '0 : dwell_cnt;
        cur_ch   = ptr;
        smp_data = '0;
        smp_ch   = ptr;
        smp_err  = 1'b0;
        nxt_ptr  = ptr;
        nxt_cnt  = '0;
        sel_idx  = int'(sel);
        if (mode) begin
            // A masked pointer jumps forward and restarts its dwell before sampling.
            cur_ch = first_enabled(int'(ptr), mask_eff);
            if (cur_ch != ptr) base_cnt = '0;
            smp_ch   = cur_ch;
            smp_data = in_data[int'(cur_ch)*W +: W];
            if (base_cnt >= dwell) begin
                nxt_cnt = '0;
                nxt_ptr = next_after(cur_ch, mask_eff);
            end else begin
                nxt_cnt = base_cnt + DWELL_W'(1);
                nxt_ptr = cur_ch;
            end
        end else begin
            smp_ch = sel;
            if (sel_idx < N && mask_eff[sel_idx]) begin
                smp_data = in_data[sel_idx*W +: W];
            end else begin
                smp_err = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            ptr       <= '0;
            dwell_cnt <= '0;
            mode_q    <= 1'b0;
        end else begin
            // Mode history only advances outside a stall so a frozen cycle stays fully frozen.
            if (!stall) mode_q <= mode;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= smp_data;
                out_ch    <= smp_ch;
                out_err   <= smp_err;
                ptr       <= nxt_ptr;
                dwell_cnt <= nxt_cnt;
            end else if (!stall) begin
                out_valid <= 1'b0;
                if (mode_chg) dwell_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_muxn_scan.sv
// Self-checking bench for muxn_scan (N=6): directed steps plus randomized traffic vs a behavioural model.
module tb_muxn_scan;
    localparam int N  = 6;
    localparam int W  = 8;
    localparam int DW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic           en, mode, out_ready;
    logic [2:0]     sel;
    logic [DW-1:0]  dwell;
    logic [N-1:0]   mask;
    logic [W-1:0]   out_data;
    logic [2:0]     out_ch;
    logic           out_err, out_valid;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic       m_valid, m_err, m_prev_mode;
    logic [2:0] m_ch;
    logic [7:0] m_data;
    int         m_ptr, m_cnt;

    muxn_scan #(.N(N), .W(W), .DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .en(en), .mode(mode),
        .sel(sel), .dwell(dwell),
`ifdef MUXN_SCAN_MASK_EN
        .ch_mask(mask),
`endif
        .out_data(out_data), .out_ch(out_ch), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int next_en(input int c);
        for (int k = 1; k <= N; k++)
            if (mask[(c + k) % N]) return (c + k) % N;
        return c;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_err = 0; m_ch = 0; m_data = 0;
        m_ptr = 0; m_cnt = 0; m_prev_mode = 0;
    endtask

    // One rising edge of the specified behaviour, using the inputs currently driven.
    task automatic model_step();
        bit chg;
        int c, cnt;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_valid && !out_ready) return;
        chg = (mode != m_prev_mode);
        m_prev_mode = mode;
        if (en && !(mode && mask == 0)) begin
            m_valid = 1;
            if (mode) begin
                c   = m_ptr;
                cnt = chg ? 0 : m_cnt;
                if (!mask[c]) begin
                    c   = next_en(c - 1 + N);
                    cnt = 0;
                end
                m_ch = 3'(c); m_err = 0; m_data = in_data[c*W +: W];
                if (cnt >= int'(dwell)) begin
                    m_cnt = 0;
                    m_ptr = next_en(c);
                end else begin
                    m_cnt = cnt + 1;
                    m_ptr = c;
                end
            end else begin
                m_ch = sel;
                if (int'(sel) >= N || !mask[sel]) begin
                    m_err = 1; m_data = 0;
                end else begin
                    m_err = 0; m_data = in_data[int'(sel)*W +: W];
                end
                m_cnt = 0;
            end
        end else begin
            m_valid = 0;
            if (chg) m_cnt = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("model", {out_valid, out_err, out_ch, out_data}, {m_valid, m_err, m_ch, m_data});
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int c = 0; c < N; c++) in_data[c*W +: W] = 8'($urandom);
    endtask

    initial begin
        rst = 1; en = 0; mode = 0; sel = 0; dwell = 0; out_ready = 1;
        in_data = '0; mask = '1;
        model_reset();
        #1;
        check("reset_state", {out_valid, out_err, out_ch, out_data}, 13'd0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // manual select
        rand_data();
        in_data[5*W +: W] = 8'hA5;
        sel = 5; en = 1;
        cyc();
        check("manual_a5", {out_valid, out_err, out_ch, out_data}, {1'b1, 1'b0, 3'd5, 8'hA5});
        sel = 7;
        cyc();
        check("sel_oob", {out_valid, out_err, out_ch, out_data}, {1'b1, 1'b1, 3'd7, 8'h00});

        // reset while holding a sample
        out_ready = 0; sel = 2;
        rst = 1;
        #1;
        check("rst_async", {out_valid, out_err, out_ch, out_data}, 13'd0);
        cyc();
        check("rst_hold", {30'd0, out_valid}, 0);
        rst = 0; out_ready = 1;

        // scan, dwell=1, with a 3-cycle stall at channel 2
        mode = 1; dwell = 1;
        for (int i = 0; i < 17; i++) begin
            rand_data();
            cyc();
            check("scan_seq", {29'd0, out_ch}, (i / 2) % N);
        end
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cyc();
            check("stall_ch", {28'd0, out_valid, out_ch}, {1'b1, 3'd2});
        end
        out_ready = 1;
        for (int i = 17; i < 20; i++) begin
            rand_data();
            cyc();
            check("resume_seq", {29'd0, out_ch}, (i / 2) % N);
        end

        // drain, then mode 1->0->1 keeps ptr and clears dwell count
        en = 0;
        cyc();
        check("drain", {31'd0, out_valid}, 0);
        en = 1; mode = 0; sel = 1;
        cyc();
        mode = 1;
        cyc();
        check("mode_resume", {29'd0, out_ch}, 4);
        cyc();
        check("mode_dwell", {29'd0, out_ch}, 4);
        cyc();
        check("mode_next", {29'd0, out_ch}, 5);

`ifdef MUXN_SCAN_MASK_EN
        rst = 1;
        cyc();
        rst = 0; mask = 6'b100010; dwell = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("mask_seq", {29'd0, out_ch}, (i % 2 == 0) ? 1 : 5);
        end
        mask = '0;
        cyc();
        check("mask_zero_drain", {31'd0, out_valid}, 0);
        mode = 0; sel = 1;
        cyc();
        check("mask_manual_err", {out_err, out_data}, {1'b1, 8'h00});
        mask = 6'b011011;
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            dwell = DW'($urandom_range(0, 3));
            sel   = 3'($urandom_range(0, 7));
`ifdef MUXN_SCAN_MASK_EN
            if ($urandom_range(0, 31) == 0) mask = N'($urandom);
`endif
            rand_data();
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
